// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS memory-access stage.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    // Low address bits that must be zero for a word access
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
        return |(addr[1:0] & WORD_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register; a stall inserts a bubble while data fields hold.
module memwb_reg
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_bubble,
    input  logic [DATA_W-1:0] i_alures,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic              i_regwrite,
    input  logic              i_memtoreg,
    input  logic              i_buserr,
    input  logic              i_rdata_load,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_alures,
    output logic [DATA_W-1:0] o_rdata,
    output logic [REG_AW-1:0] o_waddr,
    output logic              o_regwrite,
    output logic              o_memtoreg,
    output logic              o_buserr
);

    logic [DATA_W-1:0] r_alures;
    logic [DATA_W-1:0] r_rdata;
    logic [REG_AW-1:0] r_waddr;
    logic              r_regwrite;
    logic              r_memtoreg;
    logic              r_buserr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alures   <= '0;
            r_rdata    <= '0;
            r_waddr    <= '0;
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_buserr   <= 1'b0;
        end else begin
            if (i_bubble) begin
                r_regwrite <= 1'b0;
                r_memtoreg <= 1'b0;
                r_buserr   <= 1'b0;
            end else begin
                r_alures   <= i_alures;
                r_waddr    <= i_waddr;
                r_regwrite <= i_regwrite;
                r_memtoreg <= i_memtoreg;
                r_buserr   <= i_buserr;
            end
            // Load data is captured only in the ack cycle of a read
            if (i_rdata_load) begin
                r_rdata <= i_rdata;
            end
        end
    end

    assign o_alures   = r_alures;
    assign o_rdata    = r_rdata;
    assign o_waddr    = r_waddr;
    assign o_regwrite = r_regwrite;
    assign o_memtoreg = r_memtoreg;
    assign o_buserr   = r_buserr;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS M stage: runs loads/stores over a req/ack bus with stall, alignment check and timeout.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ALUResM,
    input  logic [DATA_W-1:0] RegD2M,
    input  logic [REG_AW-1:0] RegWriteAddrM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              StallM,
    output logic [DATA_W-1:0] ALUResW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [REG_AW-1:0] RegWriteAddrW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic              BusErrW
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t     r_state;
    mem_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic w_access;
    logic w_misaligned;
    logic w_aligned_acc;
    logic w_req;
    logic w_stall;
    logic w_timeout;
    logic w_abort;
    logic w_rdata_load;

    assign w_access      = MemtoRegM | MemWriteM;
    assign w_misaligned  = w_access & is_misaligned(ALUResM);
    assign w_aligned_acc = w_access & ~w_misaligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_aligned_acc) begin
                    w_req = 1'b1;
                    if (!mem_ack) begin
                        w_stall     = 1'b1;
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            BUSY: begin
                // M inputs are frozen by StallM, so the bus fields stay stable here
                w_req = 1'b1;
                if (mem_ack) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bus and stall are forced low the instant reset asserts
    assign mem_req   = w_req & ~rst;
    assign mem_we    = w_req & MemWriteM & ~rst;
    assign mem_addr  = rst ? '0 : ALUResM;
    assign mem_wdata = rst ? '0 : RegD2M;
    assign StallM    = w_stall & ~rst;

    assign w_abort      = w_misaligned | w_timeout;
    assign w_rdata_load = w_req & mem_ack & ~MemWriteM;

    memwb_reg u_memwb (
        .clk          (clk),
        .rst          (rst),
        .i_bubble     (w_stall),
        .i_alures     (ALUResM),
        .i_waddr      (RegWriteAddrM),
        .i_regwrite   (RegWriteM & ~w_abort),
        .i_memtoreg   (MemtoRegM & ~MemWriteM & ~w_abort),
        .i_buserr     (w_abort),
        .i_rdata_load (w_rdata_load),
        .i_rdata      (mem_rdata),
        .o_alures     (ALUResW),
        .o_rdata      (ReadDataW),
        .o_waddr      (RegWriteAddrW),
        .o_regwrite   (RegWriteW),
        .o_memtoreg   (MemtoRegW),
        .o_buserr     (BusErrW)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage with directed bus transactions (TIMEOUT_CYCLES=4).
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUResM, RegD2M, mem_rdata;
    logic [4:0]  RegWriteAddrM;
    logic        RegWriteM, MemtoRegM, MemWriteM, mem_ack;
    logic        mem_req, mem_we, StallM;
    logic [31:0] mem_addr, mem_wdata, ALUResW, ReadDataW;
    logic [4:0]  RegWriteAddrW;
    logic        RegWriteW, MemtoRegW, BusErrW;

    logic        tb_vld = 1'b0;
    logic        pending = 1'b0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rd;
        logic [4:0]  wa;
        logic        rw;
        logic        m2r;
        logic        berr;
    } wexp_t;

    wexp_t sb[$];
    wexp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ALUResM(ALUResM), .RegD2M(RegD2M), .RegWriteAddrM(RegWriteAddrM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .StallM(StallM),
        .ALUResW(ALUResW), .ReadDataW(ReadDataW), .RegWriteAddrW(RegWriteAddrW),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .BusErrW(BusErrW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: an instruction accepted in one cycle appears in W one edge later
    always @(negedge clk) begin
        if (pending) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ALUResW", ALUResW, mon_e.alu);
                chk("ReadDataW", ReadDataW, mon_e.rd);
                chk("RegWriteAddrW", {27'd0, RegWriteAddrW}, {27'd0, mon_e.wa});
                chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, mon_e.rw});
                chk("MemtoRegW", {31'd0, MemtoRegW}, {31'd0, mon_e.m2r});
                chk("BusErrW", {31'd0, BusErrW}, {31'd0, mon_e.berr});
            end
        end
        pending = tb_vld & ~StallM & ~rst;
    end

    task automatic set_nop();
        ALUResM = 32'h0; RegD2M = 32'h0; RegWriteAddrM = 5'd0;
        RegWriteM = 1'b0; MemtoRegM = 1'b0; MemWriteM = 1'b0;
        mem_ack = 1'b0; tb_vld = 1'b0;
    endtask

    // Presents one instruction; ack is raised in cycle 'waits' (never if waits<0)
    task automatic issue(input string name, input logic [31:0] alu, input logic [31:0] d2,
                         input logic [4:0] wa, input logic rw, input logic m2r, input logic mw,
                         input int waits, input logic [31:0] rdata,
                         input int exp_stall, input int exp_req, input wexp_t ex);
        int  stalls;
        int  reqs;
        bit  done;
        stalls = 0; reqs = 0; done = 1'b0;
        sb.push_back(ex);
        ALUResM = alu; RegD2M = d2; RegWriteAddrM = wa;
        RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
        mem_rdata = rdata; tb_vld = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            mem_ack = (c == waits);
            @(negedge clk);
            if (c == 0 && mem_req) begin
                chk({name, "_we"}, {31'd0, mem_we}, {31'd0, mw});
                chk({name, "_addr"}, mem_addr, alu);
                chk({name, "_wdata"}, mem_wdata, d2);
            end
            if (mem_req) reqs++;
            if (StallM) stalls++;
            else done = 1'b1;
            @(posedge clk); #1;
        end
        chk({name, "_completed"}, {31'd0, done}, 32'd1);
        chk({name, "_stall_cycles"}, stalls, exp_stall);
        if (exp_req >= 0) chk({name, "_req_cycles"}, reqs, exp_req);
        set_nop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        set_nop();
        RegD2M = 32'h0;
        mem_rdata = 32'h0;
        rst = 1'b1;
        // Aligned load held at the inputs during reset must not reach the bus
        ALUResM = 32'h100; MemtoRegM = 1'b1; RegD2M = 32'hABCD;
        #12;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_StallM", {31'd0, StallM}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_W", {ALUResW[15:0], 11'd0, RegWriteAddrW}, 32'd0);
        chk("rst_Wctl", {29'd0, RegWriteW, MemtoRegW, BusErrW}, 32'd0);
        chk("rst_ReadDataW", ReadDataW, 32'd0);
        @(posedge clk); #1;
        set_nop();
        rst = 1'b0;
        @(posedge clk); #1;

        issue("rtype", 32'h0000_1234, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, -1, 32'h0, 0, 0,
              '{alu: 32'h1234, rd: 32'h0, wa: 5'd3, rw: 1'b1, m2r: 1'b0, berr: 1'b0});

        issue("load0", 32'h100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 0, 32'hDEAD_BEEF, 0, 1,
              '{alu: 32'h100, rd: 32'hDEAD_BEEF, wa: 5'd5, rw: 1'b1, m2r: 1'b1, berr: 1'b0});

        issue("store3", 32'h200, 32'h55, 5'd0, 1'b0, 1'b0, 1'b1, 3, 32'h1111_1111, 3, 4,
              '{alu: 32'h200, rd: 32'hDEAD_BEEF, wa: 5'd0, rw: 1'b0, m2r: 1'b0, berr: 1'b0});

        // ack asserted alongside the misaligned load must be ignored
        issue("misalign", 32'h102, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 0, 32'h2222_2222, 0, 0,
              '{alu: 32'h102, rd: 32'hDEAD_BEEF, wa: 5'd7, rw: 1'b0, m2r: 1'b0, berr: 1'b1});

        issue("timeout", 32'h300, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, -1, 32'h0, TO, -1,
              '{alu: 32'h300, rd: 32'hDEAD_BEEF, wa: 5'd9, rw: 1'b0, m2r: 1'b0, berr: 1'b1});
        mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
        @(negedge clk);
        chk("post_to_mem_req", {31'd0, mem_req}, 32'd0);
        chk("post_to_StallM", {31'd0, StallM}, 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stale_ack_ReadDataW", ReadDataW, 32'hDEAD_BEEF);
        chk("nop_BusErrW", {31'd0, BusErrW}, 32'd0);
        @(posedge clk); #1;

        issue("ldst_both", 32'h400, 32'hAA, 5'd2, 1'b1, 1'b1, 1'b1, 1, 32'h4444_4444, 1, 2,
              '{alu: 32'h400, rd: 32'hDEAD_BEEF, wa: 5'd2, rw: 1'b1, m2r: 1'b0, berr: 1'b0});

        issue("b2b_a", 32'h500, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1, 32'h5555_5555, 1, 2,
              '{alu: 32'h500, rd: 32'h5555_5555, wa: 5'd10, rw: 1'b1, m2r: 1'b1, berr: 1'b0});
        issue("b2b_b", 32'h504, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 0, 32'h6666_6666, 0, 1,
              '{alu: 32'h504, rd: 32'h6666_6666, wa: 5'd11, rw: 1'b1, m2r: 1'b1, berr: 1'b0});

        // Reset while the bus access is outstanding
        ALUResM = 32'h600; MemtoRegM = 1'b1; RegWriteM = 1'b1; RegWriteAddrM = 5'd4;
        mem_ack = 1'b0; tb_vld = 1'b0;
        @(negedge clk);
        chk("busy_entry_StallM", {31'd0, StallM}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_mem_req", {31'd0, mem_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_StallM", {31'd0, StallM}, 32'd0);
        chk("midrst_ReadDataW", ReadDataW, 32'd0);
        chk("midrst_Wctl", {29'd0, RegWriteW, MemtoRegW, BusErrW}, 32'd0);
        @(posedge clk); #1;
        set_nop();
        rst = 1'b0;
        @(posedge clk); #1;

        issue("after_rst", 32'h700, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 2, 32'h7777_7777, 2, 3,
              '{alu: 32'h700, rd: 32'h7777_7777, wa: 5'd12, rw: 1'b1, m2r: 1'b1, berr: 1'b0});

        @(negedge clk); #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
